alu_arbiter: RTL



---
 rtl/alu_arbiter_if.sv | 22 ++
 rtl/alu_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester port bundle: op request handshake plus result response handshake
interface alu_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_opcode;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;

  modport master (
    output req_valid, req_opcode, req_a, req_b, req_imm, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_imm, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one combinational ALU, with response buffers and N/Z/V flags
module alu_arbiter (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_arbiter_if.slave       port0,
  alu_arbiter_if.slave       port1,
  output logic [15:0]        alu_src_data_1,
  output logic [15:0]        alu_src_data_2,
  output logic [3:0]         alu_immediate,
  output logic [3:0]         alu_opcode,
  input  logic [15:0]        alu_result,
  input  logic [2:0]         alu_flags,
  output logic [2:0]         flags
);

  // issue stage
  logic        ex_valid;
  logic        ex_id;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_a;
  logic [15:0] ex_b;
  logic [3:0]  ex_imm;
  logic        last_grant;

  // response buffers and flag register
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [15:0] rsp0_result;
  logic [15:0] rsp1_result;
  logic [2:0]  flags_q;

  // arbitration terms
  logic elig0, elig1;
  logic cand0, cand1;
  logic grant0, grant1;
  logic accept0, accept1;
  logic complete0, complete1;

  // Eligibility, round-robin grant and accept; a requester with an op in the
  // issue stage or a response that cannot drain this cycle is held off.
  always_comb begin
    elig0     = !(ex_valid && !ex_id) && (!rsp0_valid || port0.rsp_ready);
    elig1     = !(ex_valid &&  ex_id) && (!rsp1_valid || port1.rsp_ready);
    cand0     = port0.req_valid && elig0;
    cand1     = port1.req_valid && elig1;
    grant0    = cand0 && (!cand1 ||  last_grant);
    grant1    = cand1 && (!cand0 || !last_grant);
    accept0   = grant0 && !flush;
    accept1   = grant1 && !flush;
    complete0 = ex_valid && !ex_id && !flush;
    complete1 = ex_valid &&  ex_id && !flush;
  end

  assign port0.req_ready = accept0;
  assign port1.req_ready = accept1;
  assign port0.rsp_valid  = rsp0_valid;
  assign port1.rsp_valid  = rsp1_valid;
  assign port0.rsp_result = rsp0_result;
  assign port1.rsp_result = rsp1_result;

  assign alu_src_data_1 = ex_a;
  assign alu_src_data_2 = ex_b;
  assign alu_immediate  = ex_imm;
  assign alu_opcode     = ex_opcode;
  assign flags          = flags_q;

  // Issue stage: load the granted request; operands hold when idle so the ALU inputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_id      <= 1'b0;
      ex_opcode  <= 4'd0;
      ex_a       <= 16'd0;
      ex_b       <= 16'd0;
      ex_imm     <= 4'd0;
      last_grant <= 1'b1;
    end else if (accept0 || accept1) begin
      ex_valid   <= 1'b1;
      ex_id      <= accept1;
      last_grant <= accept1;
      ex_opcode  <= accept1 ? port1.req_opcode : port0.req_opcode;
      ex_a       <= accept1 ? port1.req_a      : port0.req_a;
      ex_b       <= accept1 ? port1.req_b      : port0.req_b;
      ex_imm     <= accept1 ? port1.req_imm    : port0.req_imm;
    end else begin
      ex_valid   <= 1'b0;
    end
  end

  // Response buffers: a completion overrides a same-edge drain; flush empties both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_result <= 16'd0;
      rsp1_result <= 16'd0;
    end else if (flush) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      if (complete0) begin
        rsp0_result <= alu_result;
        rsp0_valid  <= 1'b1;
      end else if (rsp0_valid && port0.rsp_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (complete1) begin
        rsp1_result <= alu_result;
        rsp1_valid  <= 1'b1;
      end else if (rsp1_valid && port1.rsp_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

  // Flag register {N,Z,V}: arithmetic writes all, logic/shift ops write Z only, the rest leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (ex_valid && !flush) begin
      case (ex_opcode)
        4'd0, 4'd1:             flags_q    <= alu_flags;
        4'd3, 4'd4, 4'd5, 4'd6: flags_q[1] <= alu_flags[1];
        default:                flags_q    <= flags_q;
      endcase
    end
  end

endmodule
